bicubic_tap_fetch: RTL and testbench

- Source-side feeder for the bicubic interpolation datapath. Accepts one interpolation request (integer pixel coordinate plus direction) and reads the four neighbour pixels P(-1), P(0), P(1), P(2) from the source-image ROM.
- Clamps out-of-image coordinates to the nearest edge.
- Presents the four taps to the cubic core over a valid/ready handshake. It is the producer end of the cubic core's P-input interface.

---
 rtl/bicubic_pkg.sv | 17 +
 rtl/bicubic_tap_fetch_if.sv | 34 +++
 rtl/bicubic_addr_gen.sv | 47 ++++
 rtl/bicubic_tap_fetch.sv | 179 +++++++++++++++++
 tb/tb_bicubic_tap_fetch.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/bicubic_pkg.sv
// Shared constants for the bicubic tap fetcher: default geometry, tap count, FSM encoding.
package bicubic_pkg;

  localparam int IMG_W_DEF  = 100;
  localparam int IMG_H_DEF  = 100;
  localparam int ADDR_W_DEF = 14;
  localparam int PIX_W_DEF  = 8;
  localparam int NUM_TAPS   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/bicubic_tap_fetch_if.sv
// Request, ROM and tap handshake bundle of the bicubic tap fetcher.
// The master modport is the fetcher; slave is its environment (requester, ROM, cubic core).
interface bicubic_tap_fetch_if
  import bicubic_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PIX_W  = PIX_W_DEF
);
  logic              req_valid;
  logic              req_ready;
  logic [6:0]        req_x;
  logic [6:0]        req_y;
  logic              req_dir;
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [PIX_W-1:0]  rom_q;
  logic              tap_valid;
  logic              tap_ready;
  logic [PIX_W-1:0]  tap0;
  logic [PIX_W-1:0]  tap1;
  logic [PIX_W-1:0]  tap2;
  logic [PIX_W-1:0]  tap3;
  logic              busy;

  modport master (
    input  req_valid, req_x, req_y, req_dir, rom_q, tap_ready,
    output req_ready, rom_ce, rom_addr, tap_valid, tap0, tap1, tap2, tap3, busy
  );

  modport slave (
    output req_valid, req_x, req_y, req_dir, rom_q, tap_ready,
    input  req_ready, rom_ce, rom_addr, tap_valid, tap0, tap1, tap2, tap3, busy
  );
endinterface

// File: rtl/bicubic_addr_gen.sv
// Combinational tap address generator: edge-clamps tap k and the orthogonal
// coordinate, then forms row*IMG_W + col with a constant multiply.
module bicubic_addr_gen
  import bicubic_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [6:0]        x_i,
  input  logic [6:0]        y_i,
  input  logic              dir_i,
  input  logic [1:0]        k_i,
  output logic [6:0]        coord_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic [6:0]        c;
  logic [6:0]        o;
  logic [6:0]        c_max;
  logic [6:0]        o_max;
  logic [6:0]        o_clamp;
  logic [6:0]        row;
  logic [6:0]        col;
  logic signed [8:0] ck;

  always_comb begin
    c     = dir_i ? y_i : x_i;
    o     = dir_i ? x_i : y_i;
    c_max = dir_i ? 7'(IMG_H - 1) : 7'(IMG_W - 1);
    o_max = dir_i ? 7'(IMG_W - 1) : 7'(IMG_H - 1);
    // 9-bit signed so both c-1 = -1 and 127+2 are representable without wrap
    ck    = $signed({2'b00, c}) + $signed({7'b0, k_i}) - 9'sd1;
    if (ck[8]) begin
      coord_o = '0;
    end else if (ck[7:0] > {1'b0, c_max}) begin
      coord_o = c_max;
    end else begin
      coord_o = ck[6:0];
    end
    o_clamp = (o > o_max) ? o_max : o;
    row     = dir_i ? coord_o : o_clamp;
    col     = dir_i ? o_clamp : coord_o;
    addr_o  = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
  end

endmodule

// File: rtl/bicubic_tap_fetch.sv
// Bicubic tap fetcher: reads P(-1)..P(2) around a request from the source ROM
// and hands them to the cubic core. Optional shift-reuse under `TAP_REUSE_EN.
//
// state    | meaning
// IDLE     | waiting for a request, req_ready=1
// READ     | rom_ce=1, address of tap k; captures tap k-1 from rom_q
// DRAIN    | last ROM word returns, captured into tap3
// HOLD     | tap_valid=1 until the cubic core takes the taps
module bicubic_tap_fetch
  import bicubic_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PIX_W  = PIX_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  bicubic_tap_fetch_if.master bus
);

  state_t            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [6:0]        x_q, x_d;
  logic [6:0]        y_q, y_d;
  logic              dir_q, dir_d;
  logic [PIX_W-1:0]  tap_q [NUM_TAPS];
  logic [PIX_W-1:0]  tap_d [NUM_TAPS];
  logic [ADDR_W-1:0] gen_addr;
  logic [6:0]        unused_coord;
  logic              cap_en;

  bicubic_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .x_i     (x_q),
    .y_i     (y_q),
    .dir_i   (dir_q),
    .k_i     (k_q),
    .coord_o (unused_coord),
    .addr_o  (gen_addr)
  );

`ifdef TAP_REUSE_EN
  logic       reuse_q, reuse_d;
  logic       prev_vld_q, prev_vld_d;
  logic       prev_dir_q, prev_dir_d;
  logic [6:0] prev_c_q, prev_c_d;
  logic [6:0] prev_o_q, prev_o_d;
  logic [6:0] new_c;
  logic [6:0] new_o;
  logic [6:0] new_c_max;
  logic [6:0] new_o_max;
  logic       reuse_hit;

  // A hit needs both the previous and the new window fully inside the image
  always_comb begin
    new_c     = bus.req_dir ? bus.req_y : bus.req_x;
    new_o     = bus.req_dir ? bus.req_x : bus.req_y;
    new_c_max = bus.req_dir ? 7'(IMG_H - 1) : 7'(IMG_W - 1);
    new_o_max = bus.req_dir ? 7'(IMG_W - 1) : 7'(IMG_H - 1);
    reuse_hit = prev_vld_q && (bus.req_dir == prev_dir_q) && (new_o == prev_o_q) &&
                ({1'b0, new_c} == ({1'b0, prev_c_q} + 8'd1)) && (new_c >= 7'd2) &&
                (({1'b0, new_c} + 8'd2) <= {1'b0, new_c_max}) && (new_o <= new_o_max);
  end
  assign cap_en = (k_q != 2'd0) && !reuse_q;
`else
  assign cap_en = (k_q != 2'd0);
`endif

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    x_d           = x_q;
    y_d           = y_q;
    dir_d         = dir_q;
    tap_d         = tap_q;
    bus.req_ready = 1'b0;
    bus.rom_ce    = 1'b0;
    bus.tap_valid = 1'b0;
`ifdef TAP_REUSE_EN
    reuse_d    = reuse_q;
    prev_vld_d = prev_vld_q;
    prev_dir_d = prev_dir_q;
    prev_c_d   = prev_c_q;
    prev_o_d   = prev_o_q;
`endif
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          x_d     = bus.req_x;
          y_d     = bus.req_y;
          dir_d   = bus.req_dir;
          k_d     = 2'd0;
          state_d = ST_READ;
`ifdef TAP_REUSE_EN
          reuse_d = reuse_hit;
          if (reuse_hit) begin
            k_d      = 2'd3;
            tap_d[0] = tap_q[1];
            tap_d[1] = tap_q[2];
            tap_d[2] = tap_q[3];
          end
`endif
        end
      end
      ST_READ: begin
        bus.rom_ce = 1'b1;
        if (cap_en) begin
          tap_d[k_q - 2'd1] = bus.rom_q;
        end
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        tap_d[3] = bus.rom_q;
        state_d  = ST_HOLD;
      end
      ST_HOLD: begin
        bus.tap_valid = 1'b1;
        if (bus.tap_ready) begin
          state_d = ST_IDLE;
`ifdef TAP_REUSE_EN
          prev_vld_d = 1'b1;
          prev_dir_d = dir_q;
          prev_c_d   = dir_q ? y_q : x_q;
          prev_o_d   = dir_q ? x_q : y_q;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= 1'b0;
      tap_q   <= '{default: '0};
`ifdef TAP_REUSE_EN
      reuse_q    <= 1'b0;
      prev_vld_q <= 1'b0;
      prev_dir_q <= 1'b0;
      prev_c_q   <= '0;
      prev_o_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      tap_q   <= tap_d;
`ifdef TAP_REUSE_EN
      reuse_q    <= reuse_d;
      prev_vld_q <= prev_vld_d;
      prev_dir_q <= prev_dir_d;
      prev_c_q   <= prev_c_d;
      prev_o_q   <= prev_o_d;
`endif
    end
  end

  assign bus.rom_addr = (state_q == ST_READ) ? gen_addr : '0;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.tap0     = tap_q[0];
  assign bus.tap1     = tap_q[1];
  assign bus.tap2     = tap_q[2];
  assign bus.tap3     = tap_q[3];

endmodule

// File: tb/tb_bicubic_tap_fetch.sv
// Directed bench for bicubic_tap_fetch; ROM model returns the previous rom_addr[7:0].
// Reuse expectations switch with `TAP_REUSE_EN.
module tb_bicubic_tap_fetch;
  import bicubic_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bicubic_tap_fetch_if #(.ADDR_W(ADDR_W_DEF), .PIX_W(PIX_W_DEF)) bus ();

  bicubic_tap_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_q <= bus.rom_addr[7:0];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents a request and returns right after its accepting edge.
  task automatic issue(input string tag, input int x, input int y, input int dir);
    @(negedge clk);
    bus.req_x     = 7'(x);
    bus.req_y     = 7'(y);
    bus.req_dir   = dir[0];
    bus.req_valid = 1'b1;
    chk({tag, "_req_ready"}, int'(bus.req_ready), 1);
    @(posedge clk);
  endtask

  // Called right after the accepting edge N; collects addresses until tap_valid.
  task automatic run_fetch(input string tag, input int exp_n, input int exp_a[4],
                           input int exp_t[4], input int exp_lat);
    int n = 0;
    int lat = -1;
    int got_a[4] = '{default: -1};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) bus.req_valid = 1'b0;
      if (bus.rom_ce) begin
        if (n < 4) got_a[n] = int'(bus.rom_addr);
        n++;
      end
      if (bus.tap_valid) begin
        lat = i;
        break;
      end
      @(posedge clk);
    end
    chk({tag, "_nreads"}, n, exp_n);
    for (int j = 0; j < exp_n; j++) chk($sformatf("%s_addr%0d", tag, j), got_a[j], exp_a[j]);
    chk({tag, "_tap0"}, int'(bus.tap0), exp_t[0]);
    chk({tag, "_tap1"}, int'(bus.tap1), exp_t[1]);
    chk({tag, "_tap2"}, int'(bus.tap2), exp_t[2]);
    chk({tag, "_tap3"}, int'(bus.tap3), exp_t[3]);
    chk({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic take_taps(input string tag);
    @(negedge clk);
    bus.tap_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.tap_ready = 1'b0;
    chk({tag, "_valid_drop"}, int'(bus.tap_valid), 0);
    chk({tag, "_idle"}, int'(bus.busy), 0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_dir   = 1'b0;
    bus.tap_ready = 1'b0;
    #12;
    chk("rst_req_ready", int'(bus.req_ready), 1);
    chk("rst_tap_valid", int'(bus.tap_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_rom_ce", int'(bus.rom_ce), 0);
    chk("rst_tap0", int'(bus.tap0), 0);
    @(negedge clk);
    rst = 1'b1;

    issue("row", 10, 2, 0);
    run_fetch("row", 4, '{209, 210, 211, 212}, '{8'hD1, 8'hD2, 8'hD3, 8'hD4}, 5);
    take_taps("row");

    issue("left", 0, 0, 0);
    run_fetch("left", 4, '{0, 0, 1, 2}, '{8'h00, 8'h00, 8'h01, 8'h02}, 5);
    take_taps("left");

    issue("right", 99, 0, 0);
    run_fetch("right", 4, '{98, 99, 99, 99}, '{8'h62, 8'h63, 8'h63, 8'h63}, 5);
    take_taps("right");

    issue("col", 5, 0, 1);
    run_fetch("col", 4, '{5, 5, 105, 205}, '{8'h05, 8'h05, 8'h69, 8'hCD}, 5);
    take_taps("col");

    // Backpressure with a second request waiting
    issue("bp", 20, 3, 0);
    run_fetch("bp", 4, '{319, 320, 321, 322}, '{8'h3F, 8'h40, 8'h41, 8'h42}, 5);
    bus.req_x     = 7'd50;
    bus.req_y     = 7'd50;
    bus.req_dir   = 1'b0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", int'(bus.tap_valid), 1);
      chk("bp_req_ready", int'(bus.req_ready), 0);
      chk("bp_rom_ce", int'(bus.rom_ce), 0);
      chk("bp_tap0", int'(bus.tap0), 8'h3F);
      chk("bp_tap3", int'(bus.tap3), 8'h42);
    end
    bus.tap_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.tap_ready = 1'b0;
    chk("bp_valid_drop", int'(bus.tap_valid), 0);
    chk("bp_idle_ready", int'(bus.req_ready), 1);
    @(posedge clk);
    run_fetch("held", 4, '{5049, 5050, 5051, 5052}, '{8'hB9, 8'hBA, 8'hBB, 8'hBC}, 5);
    take_taps("held");

    // Reset while READ is on tap 2
    issue("rstm", 30, 1, 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rstm_rom_ce", int'(bus.rom_ce), 0);
    chk("rstm_rom_addr", int'(bus.rom_addr), 0);
    chk("rstm_busy", int'(bus.busy), 0);
    chk("rstm_req_ready", int'(bus.req_ready), 1);
    chk("rstm_tap1", int'(bus.tap1), 0);
    chk("rstm_tap3", int'(bus.tap3), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rstm_no_valid", int'(bus.tap_valid), 0);
    end

    issue("post", 10, 2, 0);
    run_fetch("post", 4, '{209, 210, 211, 212}, '{8'hD1, 8'hD2, 8'hD3, 8'hD4}, 5);
    take_taps("post");

    issue("next", 11, 2, 0);
`ifdef TAP_REUSE_EN
    run_fetch("next", 1, '{213, -1, -1, -1}, '{8'hD2, 8'hD3, 8'hD4, 8'hD5}, 2);
`else
    run_fetch("next", 4, '{210, 211, 212, 213}, '{8'hD2, 8'hD3, 8'hD4, 8'hD5}, 5);
`endif
    take_taps("next");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
